// File: rtl/led_sipo_rx_if.sv
// rtl/led_sipo_rx_if.sv - serial LED link and word handshake bundle for led_sipo_rx
// Optional parity output is present when LED_SIPO_RX_PARITY_EN is defined.
interface led_sipo_rx_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic             shift;
  logic             sdata;
  logic             data_ack;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic             overrun;
`ifdef LED_SIPO_RX_PARITY_EN
  logic             parity_err;
`endif

  modport master (
    output start, shift, sdata, data_ack,
`ifdef LED_SIPO_RX_PARITY_EN
    input  parity_err,
`endif
    input  data_out, data_valid, busy, overrun
  );

  modport slave (
    input  start, shift, sdata, data_ack,
`ifdef LED_SIPO_RX_PARITY_EN
    output parity_err,
`endif
    output data_out, data_valid, busy, overrun
  );
endinterface

// File: rtl/led_sipo_rx.sv
// rtl/led_sipo_rx.sv - LSB-first serial-in/parallel-out receiver for the LED column stream
// Define LED_SIPO_RX_PARITY_EN to add a trailing even-parity bit (PAR state, parity_err output).
module led_sipo_rx #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  led_sipo_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shifter_q, shifter_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deliv_q, deliv_d;   // completed word sits in shifter_q, deliver next edge
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
`ifdef LED_SIPO_RX_PARITY_EN
  logic             pbit_q, pbit_d;
  logic             perr_q, perr_d;
`endif

  // Frame sequencing: start clears/arms, shift strobes assemble the word LSB first
  always_comb begin
    state_d   = state_q;
    shifter_d = shifter_q;
    cnt_d     = cnt_q;
    deliv_d   = 1'b0;
`ifdef LED_SIPO_RX_PARITY_EN
    pbit_d    = pbit_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shifter_d = '0;
          cnt_d     = '0;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (bus.start) begin
          shifter_d = '0;
          cnt_d     = '0;
        end else if (bus.shift) begin
          shifter_d = {bus.sdata, shifter_q[WIDTH-1:1]};
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d   = '0;
`ifdef LED_SIPO_RX_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
            deliv_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef LED_SIPO_RX_PARITY_EN
      PAR: begin
        if (bus.start) begin
          shifter_d = '0;
          cnt_d     = '0;
          state_d   = RECV;
        end else if (bus.shift) begin
          pbit_d  = bus.sdata;
          deliv_d = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RECV);
  end

  // Output handshake: deliver, replace-on-ack, or flag overrun when the consumer is behind
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
`ifdef LED_SIPO_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (valid_q && bus.data_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
`ifdef LED_SIPO_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end
    if (deliv_q) begin
      if (!valid_q || bus.data_ack) begin
        data_d  = shifter_q;
        valid_d = 1'b1;
`ifdef LED_SIPO_RX_PARITY_EN
        perr_d  = (^shifter_q) ^ pbit_q;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shifter_q <= '0;
      cnt_q     <= '0;
      deliv_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef LED_SIPO_RX_PARITY_EN
      pbit_q    <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shifter_q <= shifter_d;
      cnt_q     <= cnt_d;
      deliv_q   <= deliv_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
`ifdef LED_SIPO_RX_PARITY_EN
      pbit_q    <= pbit_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = ovr_q;
`ifdef LED_SIPO_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_led_sipo_rx.sv
// tb/tb_led_sipo_rx.sv - scoreboard bench for led_sipo_rx
module tb_led_sipo_rx;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  logic [4:0] exp_q[$];
  logic [4:0] e;

  always #5 clk = ~clk;

  led_sipo_rx_if #(.WIDTH(5)) bus ();

  led_sipo_rx #(.WIDTH(5), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.shift = 1'b1;
    bus.sdata = b;
    step();
    bus.shift = 1'b0;
    bus.sdata = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_ack();
    bus.data_ack = 1'b1;
    step();
    bus.data_ack = 1'b0;
  endtask

  // Full frame from start; ends 1ns after the edge sampling the last strobe
  task automatic send_word(input logic [4:0] w, input bit gapped, input bit push);
    do_start();
    for (int i = 0; i < 5; i++) begin
      drive_bit(w[i]);
      if (gapped && i < 4) repeat (i % 4) step();
    end
`ifdef LED_SIPO_RX_PARITY_EN
    drive_bit(^w);
`endif
    if (push) exp_q.push_back(w);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 0; bus.shift = 0; bus.sdata = 0; bus.data_ack = 0;
    step();
    total++; if (bus.data_out !== 5'd0) begin bad++; $display("FAIL rst_data got=%b exp=00000", bus.data_out); end
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.data_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b exp=0", bus.overrun); end
`ifdef LED_SIPO_RX_PARITY_EN
    total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL rst_perr got=%b exp=0", bus.parity_err); end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    do_start();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL lat_busy_recv got=%b exp=1", bus.busy); end
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    drive_bit(1'b1);
`ifdef LED_SIPO_RX_PARITY_EN
    drive_bit(1'b1);
`endif
    exp_q.push_back(5'b10000);
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL lat_early_valid got=%b exp=0", bus.data_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL lat_busy_drop got=%b exp=0", bus.busy); end
    step();
    e = exp_q.pop_front();
    total++; if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b exp=1", bus.data_valid); end
    total++; if (bus.data_out !== e) begin bad++; $display("FAIL lat_data got=%b exp=%b", bus.data_out, e); end
    do_ack();
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL lat_ack got=%b exp=0", bus.data_valid); end
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    total++; if (bus.busy !== 1'b0 || bus.data_valid !== 1'b0) begin bad++; $display("FAIL idle_shift got=busy%b valid%b exp=busy0 valid0", bus.busy, bus.data_valid); end
    send_word(5'b01101, 1'b1, 1'b1);
    step();
    e = exp_q.pop_front();
    total++; if (bus.data_valid !== 1'b1 || bus.data_out !== e) begin bad++; $display("FAIL gapped got=%b/%b exp=1/%b", bus.data_valid, bus.data_out, e); end
    do_ack();
  endtask

  task automatic test_restart();
    do_start();
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    send_word(5'b11111, 1'b0, 1'b1);
    step();
    e = exp_q.pop_front();
    total++; if (bus.data_valid !== 1'b1 || bus.data_out !== e) begin bad++; $display("FAIL restart got=%b/%b exp=1/%b", bus.data_valid, bus.data_out, e); end
    do_ack();
    // start and shift in the same cycle: the strobe must be dropped
    do_start();
    drive_bit(1'b1);
    bus.start = 1'b1; bus.shift = 1'b1; bus.sdata = 1'b1;
    step();
    bus.start = 1'b0; bus.shift = 1'b0; bus.sdata = 1'b0;
    for (int i = 0; i < 5; i++) drive_bit(i == 1 || i == 2);
`ifdef LED_SIPO_RX_PARITY_EN
    drive_bit(1'b0);
`endif
    exp_q.push_back(5'b00110);
    step();
    e = exp_q.pop_front();
    total++; if (bus.data_out !== e) begin bad++; $display("FAIL start_prio got=%b exp=%b", bus.data_out, e); end
    do_ack();
  endtask

  task automatic test_overrun();
    send_word(5'b00011, 1'b0, 1'b1);
    step();
    send_word(5'b11000, 1'b0, 1'b0);
    step(); step();
    e = exp_q.pop_front();
    total++; if (bus.data_out !== e) begin bad++; $display("FAIL ovr_data got=%b exp=%b", bus.data_out, e); end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun); end
    do_ack();
    total++; if (bus.data_valid !== 1'b0 || bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_ack got=valid%b ovr%b exp=valid0 ovr0", bus.data_valid, bus.overrun); end
  endtask

  task automatic test_ack_same_cycle();
    send_word(5'b01010, 1'b0, 1'b1);
    step();
    e = exp_q.pop_front();
    total++; if (bus.data_out !== e) begin bad++; $display("FAIL samecyc_first got=%b exp=%b", bus.data_out, e); end
    send_word(5'b10110, 1'b0, 1'b1);
    do_ack();
    e = exp_q.pop_front();
    total++; if (bus.data_valid !== 1'b1 || bus.data_out !== e || bus.overrun !== 1'b0) begin
      bad++; $display("FAIL samecyc_second got=v%b d%b o%b exp=v1 d%b o0", bus.data_valid, bus.data_out, bus.overrun, e);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    send_word(5'b11001, 1'b0, 1'b1);
    do_start();
    e = exp_q.pop_front();
    total++; if (bus.data_valid !== 1'b1 || bus.data_out !== e || bus.busy !== 1'b1) begin
      bad++; $display("FAIL b2b_first got=v%b d%b b%b exp=v1 d%b b1", bus.data_valid, bus.data_out, bus.busy, e);
    end
    do_ack();
    for (int i = 0; i < 5; i++) drive_bit(i != 2);
`ifdef LED_SIPO_RX_PARITY_EN
    drive_bit(1'b0);
`endif
    exp_q.push_back(5'b11011);
    step();
    e = exp_q.pop_front();
    total++; if (bus.data_valid !== 1'b1 || bus.data_out !== e) begin bad++; $display("FAIL b2b_second got=%b/%b exp=1/%b", bus.data_valid, bus.data_out, e); end
    do_ack();
  endtask

  task automatic test_reset_mid();
    do_start();
    drive_bit(1'b1); drive_bit(1'b1);
    rst_n = 1'b0;
    #2;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL async_rst_busy got=%b exp=0", bus.busy); end
    step();
    rst_n = 1'b1;
    step();
    send_word(5'b10101, 1'b0, 1'b1);
    step();
    e = exp_q.pop_front();
    total++; if (bus.data_valid !== 1'b1 || bus.data_out !== e) begin bad++; $display("FAIL rst_mid got=%b/%b exp=1/%b", bus.data_valid, bus.data_out, e); end
    do_ack();
  endtask

`ifdef LED_SIPO_RX_PARITY_EN
  task automatic test_parity();
    for (int p = 0; p < 2; p++) begin
      do_start();
      drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b0);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL par_busy got=%b exp=0", bus.busy); end
      drive_bit(p[0]);
      exp_q.push_back(5'b00011);
      step();
      e = exp_q.pop_front();
      total++; if (bus.data_valid !== 1'b1 || bus.data_out !== e) begin bad++; $display("FAIL par_data got=%b/%b exp=1/%b", bus.data_valid, bus.data_out, e); end
      total++; if (bus.parity_err !== p[0]) begin bad++; $display("FAIL par_err got=%b exp=%b", bus.parity_err, p[0]); end
      do_ack();
      total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL par_clr got=%b exp=0", bus.parity_err); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_gapped();
    test_restart();
    test_overrun();
    test_ack_same_cycle();
    test_back_to_back();
    test_reset_mid();
`ifdef LED_SIPO_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_sipo_rx.md
Name: led_sipo_rx

Overview:
- Serial-in/parallel-out receiver for the LED column bit stream; it is the receiving end of the load/shift serializer used on the POV LED path.
- Captures WIDTH bits LSB-first on shift strobes after a frame start, and presents the assembled word with a valid/ack handshake.
- Sits between the serial LED link and the column driver/compare logic; flags overrun when a word completes before the previous one is consumed.

Parameters:
- WIDTH, 5, bits per frame (minimum 2)
- CNT_W, 3, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  frame start; clears the receive shifter and arms reception
- shift  input  1  bit strobe; sdata is sampled when high
- sdata  input  1  serial data, LSB of the word first
- data_ack  input  1  consumer accepts data_out; clears data_valid
- data_out  output  WIDTH  last completed word, held stable while data_valid is high
- data_valid  output  1  word available; held until acknowledged
- busy  output  1  high while in RECV
- overrun  output  1  sticky: a word completed while data_valid was high and not acked

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous and active-low.
- Reset values: data_out=0, data_valid=0, busy=0, overrun=0, shifter=0, bit count=0, state=IDLE.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE and RECV. With the optional feature, also PAR.
- IDLE:
  - shift is ignored.
  - start=1 -> shifter<=0, count<=0, state<=RECV, busy=1 next cycle.
- RECV, start=1: restarts the frame. Shifter and count are cleared and the state stays RECV. start takes priority over a same-cycle shift, and that shift is discarded.
- RECV, shift=1 and start=0:
  - shifter <= {sdata, shifter[WIDTH-1:1]} and count <= count+1.
  - The first bit received ends up in bit 0.
- Completion: shift=1 while count==WIDTH-1 completes the word W={sdata, shifter[WIDTH-1:1]}. State goes to IDLE (or PAR with the optional feature) and busy drops the next cycle.
- Delivery of W, one cycle after the completing shift:
  - data_valid==0: data_out<=W, data_valid<=1.
  - data_valid==1 and data_ack==1 in the same cycle: data_out<=W and data_valid stays 1. No overrun.
  - data_valid==1 and data_ack==0: W is discarded, data_out is unchanged, overrun<=1.
- data_ack:
  - data_ack=1 with data_valid=1 and no delivery in that cycle -> data_valid<=0.
  - data_ack also clears overrun.
  - data_ack while data_valid=0 has no effect.
- Latency: data_valid rises exactly one clk after the posedge that samples the WIDTH-th shift.
- Back-to-back frames: start in the cycle after completion is accepted normally.
- Reset mid-frame discards the partial word and all outputs return to reset values immediately.

Optional Feature:
- Macro LED_SIPO_RX_PARITY_EN.
- When defined:
  - After WIDTH data bits the block enters PAR and waits for one more shift; its sdata is the even-parity bit.
  - On that shift the word is delivered, using the same rules as normal completion.
  - Adds output parity_err (1 bit): set together with delivery when ^W != parity bit, cleared on data_ack or reset.
  - start in PAR restarts the frame.
  - Delivery latency is one clk after the parity shift.
- When undefined:
  - There is no PAR state and no parity_err port.
  - Delivery follows the WIDTH-th shift as described above.

Test Plan:
1. Reset, start, then 5 shifts with sdata 0,0,0,0,1 -> data_out=5'b10000 and data_valid=1 exactly one cycle after the 5th shift; busy=0.
2. Shift pulses gapped by 0-3 idle cycles, sdata 1,0,1,1,0 -> data_out=5'b01101. shift pulses while in IDLE before start -> no state change.
3. start asserted again after 3 bits, then 5 bits 1,1,1,1,1 -> data_out=5'b11111; partial frame discarded.
4. Frame 5'b00011 left un-acked, second frame 5'b11000 completes -> data_out stays 5'b00011 and overrun=1. data_ack -> data_valid=0 and overrun=0.
5. Ack asserted in the same cycle the second word delivers -> data_valid stays 1, data_out=new word, overrun=0.
6. rst_n low mid-frame after 2 bits, then a full frame 5'b10101 -> no stale bits in the result. With LED_SIPO_RX_PARITY_EN: parity bit 0 gives parity_err=0; parity bit 1 gives parity_err=1.
